// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Immediate format codes and RV32I/RV64I opcode constants.
// Revision    : 1.0
// ============================================================================
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_J     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;
  localparam logic [2:0] IMM_ZIMM  = 3'd6;
  localparam logic [2:0] IMM_ILL   = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_illegal_fmt(input logic [2:0] fmt);
    return fmt == IMM_ILL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_fmt_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_fmt_decode
// Description : Opcode/funct3 to immediate format code.
// Revision    : 1.0
// ============================================================================
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] fmt
);

  always_comb begin
    fmt = IMM_ILL;
    case (opcode)
      OP_IMM:             fmt = (funct3[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      OP_LOAD, OP_JALR:   fmt = IMM_I;
      OP_STORE:           fmt = IMM_S;
      OP_BRANCH:          fmt = IMM_B;
      OP_JAL:             fmt = IMM_J;
      OP_LUI, OP_AUIPC:   fmt = IMM_U;
      OP_SYSTEM:          fmt = funct3[2] ? IMM_ZIMM : IMM_I;
      default:            fmt = IMM_ILL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered immediate generator with valid/ready output slot,
//               optional skid entry, flush and saturating illegal counter.
// Revision    : 1.0
// ============================================================================
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0,
  parameter int DEPTH       = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [2:0]       imm_fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [2:0]      w_fmt;
  logic [XLEN-1:0] w_ext;
  logic [5:0]      w_shamt;
  logic            w_illegal;
  logic            w_accept;

  logic            r_out_valid;
  logic [XLEN-1:0] r_ext;
  logic [2:0]      r_fmt;
  logic            r_ill;
  logic [CNT_W-1:0] r_cnt;

  generate
    if (AUTO_DECODE != 0) begin : g_auto
      logic w_unused_src;
      assign w_unused_src = ^imm_src;
      imm_fmt_decode u_dec (
        .opcode (instr[6:0]),
        .funct3 (instr[14:12]),
        .fmt    (w_fmt)
      );
    end else begin : g_manual
      logic w_unused_op;
      assign w_unused_op = ^instr[6:0];
      assign w_fmt = imm_src;
    end
  endgenerate

  assign w_shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  always_comb begin
    w_ext = '0;
    case (w_fmt)
      IMM_I:     w_ext = XLEN'($signed(instr[31:20]));
      IMM_S:     w_ext = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     w_ext = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:     w_ext = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:     w_ext = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_SHAMT: w_ext = XLEN'(w_shamt);
      IMM_ZIMM:  w_ext = XLEN'(instr[19:15]);
      default:   w_ext = '0;
    endcase
  end

  assign w_illegal = is_illegal_fmt(w_fmt);
  assign w_accept  = in_valid && in_ready;

  generate
    if (DEPTH == 2) begin : g_skid
      logic            r_skid_valid;
      logic [XLEN-1:0] r_skid_ext;
      logic [2:0]      r_skid_fmt;
      logic            r_skid_ill;

      // Ready depends only on state, never on out_ready.
      assign in_ready = !rst && !flush && !r_skid_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_valid  <= 1'b0;
          r_ext        <= '0;
          r_fmt        <= '0;
          r_ill        <= 1'b0;
          r_skid_valid <= 1'b0;
          r_skid_ext   <= '0;
          r_skid_fmt   <= '0;
          r_skid_ill   <= 1'b0;
        end else if (flush) begin
          r_out_valid  <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (r_out_valid && !out_ready) begin
          if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_ext   <= w_ext;
            r_skid_fmt   <= w_fmt;
            r_skid_ill   <= w_illegal;
          end
        end else if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_ext        <= r_skid_ext;
          r_fmt        <= r_skid_fmt;
          r_ill        <= r_skid_ill;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_ext       <= w_ext;
          r_fmt       <= w_fmt;
          r_ill       <= w_illegal;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready = !rst && !flush && (!r_out_valid || out_ready);

      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_ext       <= '0;
          r_fmt       <= '0;
          r_ill       <= 1'b0;
        end else if (flush) begin
          r_out_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_ext       <= w_ext;
          r_fmt       <= w_fmt;
          r_ill       <= w_illegal;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign imm_ext     = r_ext;
  assign imm_fmt     = r_fmt;
  assign illegal     = r_ill;
  assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed self-checking bench over four imm_gen_pipe configs.
// Revision    : 1.0
// ============================================================================
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a: XLEN32 auto depth1, b: XLEN64 auto depth1, c: XLEN32 auto depth2, d: manual CNT_W=2
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_illegal;
  logic [31:0] a_instr, a_imm_ext;
  logic [2:0]  a_imm_src, a_imm_fmt;
  logic [15:0] a_cnt;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_illegal;
  logic [31:0] b_instr;
  logic [63:0] b_imm_ext;
  logic [2:0]  b_imm_src, b_imm_fmt;
  logic [15:0] b_cnt;

  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_illegal;
  logic [31:0] c_instr, c_imm_ext;
  logic [2:0]  c_imm_src, c_imm_fmt;
  logic [15:0] c_cnt;

  logic        d_in_valid, d_in_ready, d_flush, d_out_valid, d_out_ready, d_illegal;
  logic [31:0] d_instr, d_imm_ext;
  logic [2:0]  d_imm_src, d_imm_fmt;
  logic [1:0]  d_cnt;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .DEPTH(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .instr(a_instr),
    .imm_src(a_imm_src), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm_ext(a_imm_ext), .imm_fmt(a_imm_fmt), .illegal(a_illegal), .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .DEPTH(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
    .imm_src(b_imm_src), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm_ext(b_imm_ext), .imm_fmt(b_imm_fmt), .illegal(b_illegal), .illegal_cnt(b_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .DEPTH(2), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .instr(c_instr),
    .imm_src(c_imm_src), .flush(c_flush), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .imm_ext(c_imm_ext), .imm_fmt(c_imm_fmt), .illegal(c_illegal), .illegal_cnt(c_cnt));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .DEPTH(1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .instr(d_instr),
    .imm_src(d_imm_src), .flush(d_flush), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .imm_ext(d_imm_ext), .imm_fmt(d_imm_fmt), .illegal(d_illegal), .illegal_cnt(d_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] ext, input logic [2:0] fmt, input logic ill);
    chk({tag, "_valid"}, a_out_valid, 1'b1);
    chk({tag, "_ext"},   a_imm_ext,   ext);
    chk({tag, "_fmt"},   a_imm_fmt,   fmt);
    chk({tag, "_ill"},   a_illegal,   ill);
  endtask

  initial begin
    rst = 1'b1;
    {a_in_valid, a_flush, b_in_valid, b_flush, c_in_valid, c_flush, d_in_valid, d_flush} = '0;
    {a_out_ready, b_out_ready, c_out_ready, d_out_ready} = 4'b1111;
    a_instr = '0; b_instr = '0; c_instr = '0; d_instr = '0;
    a_imm_src = '0; b_imm_src = '0; c_imm_src = '0; d_imm_src = '0;
    tick(); tick();

    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_valid",    a_out_valid, 1'b0);
    chk("rst_ext",      a_imm_ext, 32'h0);
    chk("rst_cnt",      a_cnt, 16'h0);
    chk("rst_c_ready",  c_in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", a_in_ready, 1'b1);
    chk("post_rst_c_ready", c_in_ready, 1'b1);

    // Streaming through config a with out_ready held high
    a_in_valid = 1'b1;
    a_instr = 32'hFFF00093; tick(); chk_a("addi", 32'hFFFFFFFF, 3'd0, 1'b0);
    a_instr = 32'hFE112E23; tick(); chk_a("sw",   32'hFFFFFFFC, 3'd1, 1'b0);
    a_instr = 32'hFE000EE3; tick(); chk_a("beq",  32'hFFFFFFFC, 3'd2, 1'b0);
    a_instr = 32'hFFFFF06F; tick(); chk_a("jal",  32'hFFFFFFFE, 3'd3, 1'b0);
    a_instr = 32'h123452B7; tick(); chk_a("lui",  32'h12345000, 3'd4, 1'b0);
    a_instr = 32'h4052D293; tick(); chk_a("srai", 32'h00000005, 3'd5, 1'b0);
    a_instr = 32'h800FE073; tick(); chk_a("csri", 32'h0000001F, 3'd6, 1'b0);
    a_instr = 32'h00000000; tick(); chk_a("badop", 32'h0, 3'd7, 1'b1);
    chk("a_cnt1", a_cnt, 16'd1);
    a_in_valid = 1'b0;
    tick();
    chk("a_drain_valid", a_out_valid, 1'b0);
    chk("a_cnt_hold", a_cnt, 16'd1);

    // Output hold and stall on config a
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_instr = 32'h00100093; tick();
    chk("a_stall_ready", a_in_ready, 1'b0);
    a_instr = 32'h00200093; tick();
    chk("a_hold_ext", a_imm_ext, 32'd1);
    chk("a_hold_valid", a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    #1;
    chk("a_release_ready", a_in_ready, 1'b1);
    tick();
    chk("a_replace_ext", a_imm_ext, 32'd2);
    chk("a_replace_valid", a_out_valid, 1'b1);
    a_in_valid = 1'b0;
    tick();

    // XLEN=64 config
    b_in_valid = 1'b1;
    b_instr = 32'h800002B7; tick();
    chk("b_lui_ext", b_imm_ext, 64'hFFFFFFFF80000000);
    chk("b_lui_fmt", b_imm_fmt, 3'd4);
    b_instr = 32'h03F09093; tick();
    chk("b_slli_ext", b_imm_ext, 64'h000000000000003F);
    chk("b_slli_fmt", b_imm_fmt, 3'd5);
    b_instr = 32'hFFF00093; tick();
    chk("b_addi_ext", b_imm_ext, 64'hFFFFFFFFFFFFFFFF);
    b_in_valid = 1'b0;
    tick();

    // Skid buffer: stall for three cycles with inputs offered back to back
    c_out_ready = 1'b0;
    c_in_valid = 1'b1;
    c_instr = 32'h00100093;
    chk("c_rdy0", c_in_ready, 1'b1);
    tick();
    chk("c_out1_valid", c_out_valid, 1'b1);
    chk("c_rdy1", c_in_ready, 1'b1);
    c_instr = 32'h00200093; tick();
    chk("c_rdy2", c_in_ready, 1'b0);
    chk("c_hold1", c_imm_ext, 32'd1);
    c_instr = 32'h00300093; tick();
    chk("c_rdy3", c_in_ready, 1'b0);
    chk("c_hold2", c_imm_ext, 32'd1);
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    tick();
    chk("c_drain2_valid", c_out_valid, 1'b1);
    chk("c_drain2_ext", c_imm_ext, 32'd2);
    chk("c_drain_rdy", c_in_ready, 1'b1);
    tick();
    chk("c_drain_empty", c_out_valid, 1'b0);

    // Flush with two held entries plus an illegal input offered
    c_out_ready = 1'b0;
    c_in_valid = 1'b1;
    c_instr = 32'h00400093; tick();
    c_instr = 32'h00500093; tick();
    c_flush = 1'b1;
    c_instr = 32'h00000000;
    #1;
    chk("c_flush_rdy", c_in_ready, 1'b0);
    tick();
    chk("c_flush_valid", c_out_valid, 1'b0);
    chk("c_flush_cnt", c_cnt, 16'd0);
    c_flush = 1'b0;
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    #1;
    chk("c_postflush_rdy", c_in_ready, 1'b1);
    tick();
    chk("c_postflush_valid", c_out_valid, 1'b0);

    // External imm_src, code 7 with a 2-bit saturating counter
    d_in_valid = 1'b1;
    d_imm_src = 3'd7;
    d_instr = 32'hFFFFFFFF;
    tick();
    chk("d_ill1", d_illegal, 1'b1); chk("d_ext1", d_imm_ext, 32'h0); chk("d_cnt1", d_cnt, 2'd1);
    tick();
    chk("d_ill2", d_illegal, 1'b1); chk("d_cnt2", d_cnt, 2'd2);
    tick();
    chk("d_ill3", d_illegal, 1'b1); chk("d_ext3", d_imm_ext, 32'h0); chk("d_cnt3", d_cnt, 2'd3);
    tick();
    chk("d_sat", d_cnt, 2'd3); chk("d_ill4", d_illegal, 1'b1);
    d_imm_src = 3'd4;
    d_instr = 32'h123452B7;
    tick();
    chk("d_u_ext", d_imm_ext, 32'h12345000); chk("d_u_ill", d_illegal, 1'b0);
    d_imm_src = 3'd5;
    d_instr = 32'hFFFFFFFF;
    tick();
    chk("d_shamt_ext", d_imm_ext, 32'h1F); chk("d_shamt_fmt", d_imm_fmt, 3'd5);

    // Reset in the middle of a transfer
    rst = 1'b1;
    tick();
    chk("d_rst_valid", d_out_valid, 1'b0);
    chk("d_rst_ext", d_imm_ext, 32'h0);
    chk("d_rst_fmt", d_imm_fmt, 3'd0);
    chk("d_rst_ill", d_illegal, 1'b0);
    chk("d_rst_cnt", d_cnt, 2'd0);
    chk("d_rst_rdy", d_in_ready, 1'b0);
    chk("a_rst_cnt", a_cnt, 16'd0);
    rst = 1'b0;
    d_in_valid = 1'b0;
    #1;
    chk("d_post_rdy", d_in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
